store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Posted-write FIFO between the MIPS core's data-memory write port (memwrite, dataadr, writedata) and the data memory / external bus.
- Accepts one store per cycle from the core and drains stores in order to memory over a valid/ready handshake.
- Stalls the core when full.
- Forwards the youngest matching buffered store to a concurrent load, so loads never read stale memory.

Parameters:
DEPTH, 4, number of buffered stores; power of two, minimum 2
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
memwrite  in  1  core store strobe
dataadr  in  AW  core store address (word-aligned; bits [1:0] ignored for matching)
writedata  in  DW  core store data
stall  out  1  buffer cannot accept a store this cycle; core must hold its store
ld_en  in  1  core load in progress
ld_adr  in  AW  core load address
ld_hit  out  1  a buffered store matches ld_adr[AW-1:2]
ld_data  out  DW  data of the youngest matching entry; 0 when no hit
mem_valid  out  1  head entry is presented to memory
mem_adr  out  AW  head entry address
mem_wdata  out  DW  head entry data
mem_ready  in  1  memory accepts the head entry this cycle
count  out  $clog2(DEPTH)+1  occupancy
empty  out  1  count == 0

Behaviour:
- Reset (reset low, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0, all entry valid bits cleared. Outputs during and after reset: empty = 1, mem_valid = 0, stall = 0, ld_hit = 0, ld_data = 0. mem_adr and mem_wdata are 0 while empty.
- Reset release: the first push may occur on the first rising edge after release.
- Push: push = memwrite & ~stall. The entry is written at wr_ptr, wr_ptr increments modulo DEPTH, and the entry becomes visible to mem_valid and forwarding on the next cycle. Push-to-memory latency is 1 cycle minimum.
- Pop: pop = mem_valid & mem_ready. rd_ptr increments modulo DEPTH. mem_adr, mem_wdata and mem_valid are driven directly from the head registers (no combinational path from mem_ready).
- mem_valid = ~empty. Once asserted, mem_valid and the head contents stay stable until the pop.
- stall = full & ~pop, where full = (count == DEPTH). A simultaneous push and pop when full is allowed; count stays DEPTH.
- count update: count + push − pop. A simultaneous push and pop leaves count unchanged. Pointers wrap independently via modulo DEPTH.
- Empty boundary: a store cannot bypass to memory in the same cycle; it always spends at least one cycle in the buffer.
- Forwarding (combinational):
  - Search all valid entries, comparing addr[AW-1:2].
  - On multiple matches, select the youngest: the entry closest to wr_ptr−1 going backward.
  - A store being pushed in the same cycle is NOT forwarded; the core already holds its data.
  - An entry popping in the same cycle is still forwarded that cycle.
  - ld_hit is gated by ld_en.
- Order: stores drain strictly in program order. Stores to the same address are never merged.
- memwrite with stall high: no state change; the core is required to hold its inputs.
- Reset mid-operation: all buffered stores are discarded immediately and mem_valid drops asynchronously. Discarding is intended (a core reset restarts the program).

Decomposition:
- Shared package mips_mem_pkg holds the AW/DW defaults and a store-entry struct {adr, data}.
- One sub-module: wb_fwd_match. Combinational youngest-match priority search over DEPTH entries, with inputs entries, valid vector, wr_ptr and ld_adr, and outputs hit and data.
- FIFO control and storage stay in store_write_buffer.

Test Plan:
1. Reset, then push 3 stores (adr 0x10/0x14/0x18, data 1/2/3) with mem_ready=1 -> mem_valid rises 1 cycle after the first push; memory sees 0x10/1, 0x14/2, 0x18/3 in order; empty=1 afterwards.
2. mem_ready=0, push 4 stores -> count=4, stall=1. A 5th memwrite is held until mem_ready=1 for one cycle, then accepted that same cycle with count staying 4. Each store appears exactly once at memory.
3. Push 0x54/7 then 0x54/9 (mem_ready=0), load 0x56 with ld_en=1 -> ld_hit=1, ld_data=9. Load 0x58 -> ld_hit=0, ld_data=0.
4. Wrap-around: 10 pushes/pops interleaved with mem_ready toggling every cycle, DEPTH=4 -> all 10 stores reach memory in order; count never exceeds 4.
5. Assert reset low mid-drain with 3 entries buffered -> mem_valid=0, count=0, empty=1 without waiting for a clock edge. After release, a new push of 0x3/0x3 drains as the only memory write.
6. Simultaneous push and pop at count=1 -> count stays 1. The forwarding check on the popping entry's address returns its data that cycle, with ld_hit=1.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared data-memory types for the MIPS core.
// Default address/data widths and the buffered store entry.
package mips_mem_pkg;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;

    typedef struct packed {
        logic [MEM_AW-1:0] adr;
        logic [MEM_DW-1:0] data;
    } st_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the write buffer entries.
// Ports: i_tag/i_data entries, i_vld valid bits, i_wr_ptr,
//        i_ld_tag load word address; o_hit, o_data result.
import mips_mem_pkg::*;

module wb_fwd_match #(
    parameter int DEPTH = 4,
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [AW-3:0]    i_tag [DEPTH],
    input  logic [DW-1:0]    i_data [DEPTH],
    input  logic [DEPTH-1:0] i_vld,
    input  logic [PW-1:0]    i_wr_ptr,
    input  logic [AW-3:0]    i_ld_tag,
    output logic             o_hit,
    output logic [DW-1:0]    o_data
);

    logic [PW-1:0] w_idx;

    // Walk from oldest to youngest so the youngest match wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_idx = i_wr_ptr - PW'(k + 1);
            if (i_vld[w_idx] && (i_tag[w_idx] == i_ld_tag)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between the core store port and memory.
// Ports: memwrite/dataadr/writedata in, stall out; ld_en/ld_adr in,
//        ld_hit/ld_data out; mem_valid/mem_adr/mem_wdata out,
//        mem_ready in; count/empty status.
import mips_mem_pkg::*;

module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   memwrite,
    input  logic [AW-1:0]          dataadr,
    input  logic [DW-1:0]          writedata,
    output logic                   stall,
    input  logic                   ld_en,
    input  logic [AW-1:0]          ld_adr,
    output logic                   ld_hit,
    output logic [DW-1:0]          ld_data,
    output logic                   mem_valid,
    output logic [AW-1:0]          mem_adr,
    output logic [DW-1:0]          mem_wdata,
    input  logic                   mem_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    r_adr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_hit;
    logic [DW-1:0]    w_fwd;
    logic [DEPTH-1:0] w_vld_nxt;
    logic [AW-3:0]    w_tag [DEPTH];
    logic             w_unused;

    assign w_full    = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign mem_valid = ~empty;
    assign w_pop     = mem_valid & mem_ready;
    assign stall     = w_full & ~w_pop;
    assign w_push    = memwrite & ~stall;
    assign count     = r_count;

    // Head is gated so stale storage never shows while empty.
    assign mem_adr   = empty ? '0 : r_adr[r_rd_ptr];
    assign mem_wdata = empty ? '0 : r_data[r_rd_ptr];

    // Matching ignores the byte offset within the word.
    assign w_unused  = &{1'b0, ld_adr[1:0]};

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_tag[i] = r_adr[i][AW-1:2];
        end
    end

    // Clear before set: a full push+pop reuses the head slot.
    always_comb begin
        w_vld_nxt = r_vld;
        if (w_pop) begin
            w_vld_nxt[r_rd_ptr] = 1'b0;
        end
        if (w_push) begin
            w_vld_nxt[r_wr_ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_adr[r_wr_ptr]  <= dataadr;
            r_data[r_wr_ptr] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_vld   <= w_vld_nxt;
        end
    end

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd (
        .i_tag    (w_tag),
        .i_data   (r_data),
        .i_vld    (r_vld),
        .i_wr_ptr (r_wr_ptr),
        .i_ld_tag (ld_adr[AW-1:2]),
        .o_hit    (w_hit),
        .o_data   (w_fwd)
    );

    assign ld_hit  = ld_en & w_hit;
    assign ld_data = (ld_en & w_hit) ? w_fwd : '0;

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer against a queue model.
import mips_mem_pkg::*;

module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        stall;
    logic        ld_en;
    logic [31:0] ld_adr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_valid;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [2:0]  count;
    logic        empty;

    st_entry_t q[$];
    st_entry_t sent[$];
    st_entry_t obs[$];
    int        n_tests = 0;
    int        n_fail  = 0;
    logic      tog     = 1'b0;

    always #5 clk = ~clk;

    store_write_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .stall     (stall),
        .ld_en     (ld_en),
        .ld_adr    (ld_adr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .mem_valid (mem_valid),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .count     (count),
        .empty     (empty)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One core cycle: drive, compare against the queue model, clock.
    task automatic step(input logic mw, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy,
                        input logic le, input logic [31:0] la,
                        output logic acc);
        logic        e_stall;
        logic        e_hit;
        logic        e_pop;
        logic [31:0] e_ld;
        logic [31:0] e_adr;
        logic [31:0] e_dat;
        @(negedge clk);
        memwrite  = mw;
        dataadr   = a;
        writedata = d;
        mem_ready = rdy;
        ld_en     = le;
        ld_adr    = la;
        #1;
        e_stall = (q.size() == DEPTH) && !rdy;
        e_pop   = (q.size() != 0) && rdy;
        e_hit   = 1'b0;
        e_ld    = '0;
        if (le) begin
            foreach (q[i]) begin
                if (q[i].adr[31:2] == la[31:2]) begin
                    e_hit = 1'b1;
                    e_ld  = q[i].data;
                end
            end
        end
        e_adr = (q.size() != 0) ? q[0].adr : 32'h0;
        e_dat = (q.size() != 0) ? q[0].data : 32'h0;
        chk("count", 64'(count), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
        chk("mem_adr", 64'(mem_adr), 64'(e_adr));
        chk("mem_wdata", 64'(mem_wdata), 64'(e_dat));
        chk("stall", 64'(stall), 64'(e_stall));
        chk("ld_hit", 64'(ld_hit), 64'(e_hit));
        chk("ld_data", 64'(ld_data), 64'(e_ld));
        if (mem_valid === 1'b1 && rdy) begin
            obs.push_back('{adr: mem_adr, data: mem_wdata});
        end
        acc = mw && !e_stall;
        @(posedge clk);
        if (e_pop) begin
            void'(q.pop_front());
        end
        if (acc) begin
            q.push_back('{adr: a, data: d});
            sent.push_back('{adr: a, data: d});
        end
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, acc);
        end
        #1;
        chk("drain_empty", 64'(empty), 64'(1));
    endtask

    // Memory must have seen exactly the accepted stores, in order.
    task automatic cmp_log(input string tag);
        chk({tag, "_nwrites"}, 64'(obs.size()), 64'(sent.size()));
        for (int i = 0; i < obs.size() && i < sent.size(); i++) begin
            chk({tag, "_adr"}, 64'(obs[i].adr), 64'(sent[i].adr));
            chk({tag, "_data"}, 64'(obs[i].data), 64'(sent[i].data));
        end
        obs.delete();
        sent.delete();
    endtask

    task automatic push_tog(input logic [31:0] a, input logic [31:0] d);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            tog = ~tog;
            step(1'b1, a, d, tog, 1'b0, 32'h0, acc);
        end
        chk("push_accepted", 64'(acc), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic        pend;
        logic [31:0] pa;
        logic [31:0] pd;
        reset     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        mem_ready = 1'b0;
        ld_en     = 1'b0;
        ld_adr    = '0;
        #3;
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_valid", 64'(mem_valid), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_ld_hit", 64'(ld_hit), 64'(0));
        chk("rst_ld_data", 64'(ld_data), 64'(0));
        chk("rst_mem_adr", 64'(mem_adr), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // 1: three stores drain in order with memory always ready
        step(1'b1, 32'h10, 32'h1, 1'b1, 1'b0, 32'h0, acc);
        step(1'b1, 32'h14, 32'h2, 1'b1, 1'b0, 32'h0, acc);
        step(1'b1, 32'h18, 32'h3, 1'b1, 1'b0, 32'h0, acc);
        drain();
        chk("t1_first_adr", 64'(obs.size() > 0 ? obs[0].adr : 0), 64'(32'h10));
        cmp_log("t1");

        // 2: fill, hold a fifth store, then push+pop while full
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'h20 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0,
                 1'b0, 32'h0, acc);
        end
        step(1'b1, 32'h30, 32'hA4, 1'b0, 1'b0, 32'h0, acc);
        chk("t2_held", 64'(acc), 64'(0));
        step(1'b1, 32'h30, 32'hA4, 1'b0, 1'b0, 32'h0, acc);
        step(1'b1, 32'h30, 32'hA4, 1'b1, 1'b0, 32'h0, acc);
        #1;
        chk("t2_count_full", 64'(count), 64'(DEPTH));
        drain();
        cmp_log("t2");

        // 3: youngest of two same-word stores is forwarded
        step(1'b1, 32'h54, 32'h7, 1'b0, 1'b0, 32'h0, acc);
        step(1'b1, 32'h54, 32'h9, 1'b0, 1'b0, 32'h0, acc);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h56, acc);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h58, acc);
        drain();
        cmp_log("t3");

        // 4: wrap-around with memory ready toggling every cycle
        for (int i = 0; i < 10; i++) begin
            push_tog(32'h100 + 32'(8 * i), 32'h500 + 32'(i));
        end
        drain();
        cmp_log("t4");

        // 5: asynchronous reset while draining
        step(1'b1, 32'h70, 32'h1, 1'b0, 1'b0, 32'h0, acc);
        step(1'b1, 32'h74, 32'h2, 1'b0, 1'b0, 32'h0, acc);
        step(1'b1, 32'h78, 32'h3, 1'b0, 1'b0, 32'h0, acc);
        step(1'b1, 32'h7C, 32'h4, 1'b1, 1'b0, 32'h0, acc);
        #2;
        memwrite = 1'b0;
        ld_en    = 1'b1;
        ld_adr   = 32'h78;
        reset    = 1'b0;
        #1;
        chk("t5_valid", 64'(mem_valid), 64'(0));
        chk("t5_count", 64'(count), 64'(0));
        chk("t5_empty", 64'(empty), 64'(1));
        chk("t5_ld_hit", 64'(ld_hit), 64'(0));
        q.delete();
        sent.delete();
        obs.delete();
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 32'h3, 32'h3, 1'b0, 1'b0, 32'h0, acc);
        drain();
        chk("t5_one_write", 64'(obs.size()), 64'(1));
        cmp_log("t5");

        // 6: push+pop at count 1, load hits the popping entry
        step(1'b1, 32'h60, 32'h11, 1'b0, 1'b0, 32'h0, acc);
        step(1'b1, 32'h64, 32'h22, 1'b1, 1'b1, 32'h60, acc);
        #1;
        chk("t6_count", 64'(count), 64'(1));
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h60, acc);
        drain();
        cmp_log("t6");

        // random traffic over a small address window
        pend = 1'b0;
        pa   = '0;
        pd   = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend && ($urandom_range(1, 0) == 1)) begin
                pend = 1'b1;
                pa   = 32'h40 + 32'(4 * $urandom_range(5, 0))
                     + 32'($urandom_range(3, 0));
                pd   = $urandom;
            end
            step(pend, pa, pd, 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)),
                 32'h40 + 32'(4 * $urandom_range(5, 0))
                 + 32'($urandom_range(3, 0)), acc);
            if (acc) begin
                pend = 1'b0;
            end
        end
        drain();
        cmp_log("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
